// File: rtl/if_id_skid_pkg.sv
// Shared defines for the IF/ID skid stage: reset polarity, bubble instruction
// and the state encoding (which doubles as the occupancy count).
package if_id_skid_pkg;

    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

    localparam logic [15:0] NOP_INST_DEFAULT = 16'h0800;

    // Encodings equal the number of held entries so occupancy is the state itself
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer so that fetch sees a
// registered ready while decode may stall at any time.
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int                PC_W     = 16,
    parameter int                INST_W   = 16,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [1:0]        occupancy
);

    skid_state_t       state;
    skid_state_t       next_state;
    logic              if_ready_q;
    logic              accept;
    logic              consume;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] main_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;

    assign if_ready = if_ready_q;
    assign id_valid = (state != ST_EMPTY);
    assign accept   = if_valid & if_ready;
    assign consume  = id_valid & id_ready;
    assign id_pc    = main_pc;

    // if_ready is precomputed from next_state so it never depends on id_ready this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state      <= ST_EMPTY;
            if_ready_q <= 1'b1;
        end else begin
            state      <= next_state;
            if_ready_q <= (next_state != ST_FULL);
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) next_state = ST_ONE;
                ST_ONE: begin
                    if (accept && !consume)      next_state = ST_FULL;
                    else if (consume && !accept) next_state = ST_EMPTY;
                end
                ST_FULL:  if (consume) next_state = ST_ONE;
                default:  next_state = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        occupancy      = state;
        id_inst        = id_valid ? main_inst : NOP_INST;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            load_main_in   = accept & ((state == ST_EMPTY) | ((state == ST_ONE) & consume));
            load_skid      = accept & (state == ST_ONE) & ~consume;
            load_main_skid = consume & (state == ST_FULL);
        end
    end

    // Flush only retires entries through the state; main keeps its last PC for id_pc
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            main_pc   <= '0;
            main_inst <= NOP_INST;
            skid_pc   <= '0;
            skid_inst <= '0;
        end else begin
            if (load_main_in) begin
                main_pc   <= if_pc;
                main_inst <= if_inst;
            end else if (load_main_skid) begin
                main_pc   <= skid_pc;
                main_inst <= skid_inst;
            end
            if (load_skid) begin
                skid_pc   <= if_pc;
                skid_inst <= if_inst;
            end
        end
    end

endmodule

// File: tb/tb_if_id_skid.sv
// Scoreboard bench for if_id_skid: a 16-bit and a 32-bit instance share one
// control stream and are checked against a bounded two-entry queue model.
module tb_if_id_skid;
    import if_id_skid_pkg::*;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        id_ready;
    logic [15:0] if_pc;
    logic [15:0] if_inst;
    logic [31:0] if_pc32;
    logic [31:0] if_inst32;

    logic        if_ready16, id_valid16;
    logic [15:0] id_pc16, id_inst16;
    logic [1:0]  occ16;
    logic        if_ready32, id_valid32;
    logic [31:0] id_pc32, id_inst32;
    logic [1:0]  occ32;

    entry_t      sb_q[$];
    logic [15:0] last_pc;
    logic [31:0] last_pc32;
    int          assert_count = 0;
    int          fail_count   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] map_pc(input logic [15:0] pc);
        return 32'h00400000 | {16'h0000, pc};
    endfunction

    function automatic logic [31:0] map_inst(input logic [15:0] inst);
        return 32'hDEADBEEF ^ {16'h0000, inst};
    endfunction

    assign if_pc32   = map_pc(if_pc);
    assign if_inst32 = map_inst(if_inst);

    if_id_skid dut16 (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready16), .if_pc(if_pc), .if_inst(if_inst),
        .id_valid(id_valid16), .id_ready(id_ready), .id_pc(id_pc16), .id_inst(id_inst16),
        .occupancy(occ16)
    );

    if_id_skid #(.PC_W(32), .INST_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready32), .if_pc(if_pc32), .if_inst(if_inst32),
        .id_valid(id_valid32), .id_ready(id_ready), .id_pc(id_pc32), .id_inst(id_inst32),
        .occupancy(occ32)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compares every output of both instances against the model's current contents
    task automatic sampleOutputs();
        logic exp_valid;
        logic exp_ready;
        exp_valid = (sb_q.size() != 0);
        exp_ready = (sb_q.size() < 2);
        checkOutput("valid16", {31'b0, id_valid16}, {31'b0, exp_valid});
        checkOutput("valid32", {31'b0, id_valid32}, {31'b0, exp_valid});
        checkOutput("ready16", {31'b0, if_ready16}, {31'b0, exp_ready});
        checkOutput("ready32", {31'b0, if_ready32}, {31'b0, exp_ready});
        checkOutput("occ16", {30'b0, occ16}, 32'(sb_q.size()));
        checkOutput("occ32", {30'b0, occ32}, 32'(sb_q.size()));
        if (exp_valid) begin
            last_pc   = sb_q[0].pc;
            last_pc32 = map_pc(sb_q[0].pc);
            checkOutput("head_inst16", {16'h0, id_inst16}, {16'h0, sb_q[0].inst});
            checkOutput("head_inst32", id_inst32, map_inst(sb_q[0].inst));
        end else begin
            checkOutput("nop16", {16'h0, id_inst16}, 32'h0000_0800);
            checkOutput("nop32", id_inst32, 32'h0000_0800);
        end
        checkOutput("pc16", {16'h0, id_pc16}, {16'h0, last_pc});
        checkOutput("pc32", id_pc32, last_pc32);
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] pc, input logic [15:0] inst,
                                 input logic idr, input logic fl);
        entry_t e;
        logic   m_accept;
        logic   m_consume;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = idr;
        flush    = fl;
        #1;
        sampleOutputs();
        m_accept  = v && (sb_q.size() < 2);
        m_consume = idr && (sb_q.size() != 0);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (m_consume) begin
                e = sb_q.pop_front();
                checkOutput("sb_pc16", {16'h0, id_pc16}, {16'h0, e.pc});
                checkOutput("sb_inst32", id_inst32, map_inst(e.inst));
            end
            if (m_accept) begin
                e.pc   = pc;
                e.inst = inst;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Leaves rst released at a falling edge so the next rising edge can accept
    task automatic resetDut();
        rst      = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        id_ready = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        sb_q.delete();
        last_pc   = '0;
        last_pc32 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sampleOutputs();
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] next_pc;
        resetDut();

        applyStimulus(1'b1, 16'd1, 16'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd3, 16'd8, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);

        applyStimulus(1'b1, 16'd4, 16'h0040, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd5, 16'h0050, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd6, 16'h0060, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd6, 16'h0060, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 16'd20 + 16'(i), 16'h1200 + 16'(i), 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);

        applyStimulus(1'b1, 16'd7, 16'h0070, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd8, 16'h0080, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd9, 16'h0090, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);

        applyStimulus(1'b1, 16'd10, 16'h00A0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd11, 16'h00B0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        sb_q.delete();
        last_pc   = '0;
        last_pc32 = '0;
        sampleOutputs();
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b1, 16'd12, 16'h00C0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);

        next_pc = 16'h0100;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), next_pc, next_pc ^ 16'hA5A5,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            next_pc++;
        end
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 Parameter PC_W, default 16, SHALL set the PC field width.
REQ-002 Parameter INST_W, default 16, SHALL set the instruction field width.
REQ-003 Parameter NOP_INST, default 16'h0800, SHALL be the bubble instruction driven when no entry is valid.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-low (RstEnable = 1'b0).
REQ-006 flush  in  1  SHALL discard all held instructions (branch taken, exception).
REQ-007 if_valid  in  1  SHALL mark if_pc/if_inst as valid for this cycle.
REQ-008 if_ready  out  1  SHALL indicate that the stage accepts input this cycle.
REQ-009 if_pc  in  PC_W  SHALL be the fetched PC.
REQ-010 if_inst  in  INST_W  SHALL be the fetched instruction.
REQ-011 id_valid  out  1  SHALL mark id_pc/id_inst as valid.
REQ-012 id_ready  in  1  SHALL indicate that decode consumes this cycle; it replaces the legacy stall (stall = ~id_ready).
REQ-013 id_pc  out  PC_W  SHALL be the PC of the head entry.
REQ-014 id_inst  out  INST_W  SHALL be the head instruction, or NOP_INST when id_valid = 0.
REQ-015 occupancy  out  2  SHALL give the number of held entries (0..2).

Function
REQ-016 The block SHALL hold a main entry and a skid entry, with states EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
REQ-017 Accept SHALL be defined as if_valid & if_ready; consume SHALL be defined as id_valid & id_ready.
REQ-018 if_ready SHALL be driven from a register as ~FULL, with no combinational path from id_ready.
REQ-019 id_valid SHALL equal (state != EMPTY); id_pc/id_inst SHALL always show the oldest entry.
REQ-020 Transitions:
- EMPTY: accept -> ONE.
- ONE: accept & ~consume -> FULL; consume & ~accept -> EMPTY; accept & consume -> ONE, with the new data in main.
- FULL: consume -> ONE, with skid moved to main.
REQ-021 Latency from accept to id_valid SHALL be 1 cycle.
REQ-022 With id_ready held at 1, throughput SHALL be 1 instruction per cycle with no bubbles.
REQ-023 Program order SHALL be preserved; no entry SHALL be duplicated or dropped, except by flush.
REQ-024 flush SHALL have priority over accept and consume: the next state SHALL be EMPTY, and any input offered in the flush cycle SHALL be dropped.
REQ-025 In the cycle after a flush, id_valid SHALL be 0, id_inst SHALL be NOP_INST and if_ready SHALL be 1.
REQ-026 occupancy SHALL be 0/1/2 for EMPTY/ONE/FULL, respectively.
REQ-027 When id_valid = 0, id_pc SHALL hold its last value (don't-care for decode).

Reset
REQ-028 While rst = 0, the block SHALL immediately (asynchronously) be in state EMPTY, with:
- id_valid = 0
- id_pc = 0
- id_inst = NOP_INST
- if_ready = 1
- occupancy = 0
- skid entry cleared
REQ-029 Reset asserted mid-operation SHALL discard all entries exactly as a flush does, with no partial transfer.
REQ-030 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-031 RstEnable/RstDisable, NOP_INST and the state encodings SHALL live in the shared defines file.
REQ-032 The block SHALL be a single module with no sub-modules; the two entries SHALL be plain registers.
REQ-033 With PC_W = INST_W = 16, id_ready tied to 1 and flush tied to 0, the block SHALL be a drop-in replacement for the legacy IF/ID register.

Verification
REQ-034 Reset, then if_valid = 1 with pc = 1, inst = 1, then pc = 3, inst = 8, with id_ready = 1 -> id_pc/id_inst = 1/1, then 3/8 on consecutive cycles; occupancy = 1.
REQ-035 id_ready = 0 for 2 cycles while pc = 4, 5, 6 are offered -> 4 and 5 are held, if_ready = 0 and occupancy = 2; after id_ready = 1, the outputs are 4, 5, 6 in order with none lost.
REQ-036 FULL, then flush = 1 with if_valid = 1 (pc = 9) -> next cycle id_valid = 0, id_inst = 16'h0800, occupancy = 0, and pc 9 is never output.
REQ-037 rst driven to 0 asynchronously between clock edges while FULL -> outputs go to reset values before the next edge.
REQ-038 Simultaneous accept and consume in ONE -> occupancy stays 1 and the new instruction appears next cycle.
REQ-039 PC_W = 32, INST_W = 32 instance -> same results as REQ-034 and REQ-035 with 32-bit values 32'hDEADBEEF / 32'h00400000.
